// File: rtl/alu_seq_if.sv
// Operand/opcode request channel and result/flag response channel of the sequential ALU.
// Latency: none, this is wiring only.
// Backpressure: valid/ready on both channels; the slave owns in_ready, the master owns out_ready.
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, res, res_hi, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, res, res_hi, cout, ovf, zero
    );
endinterface

// File: rtl/alu_seq_core.sv
// Handshaked WIDTH-bit ALU: add/sub/logic/shift in one step, unsigned multiply by shift-add.
// Latency: 1 cycle from accept for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: result held stable while out_ready=0; in_ready drops in BUSY and in an unconsumed DONE.
module alu_seq_core #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    localparam int               MSB   = WIDTH - 1;
    localparam int               CW    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] W_VEC = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_step;
    logic [CW-1:0]      step_cnt;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     part_sum;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;

    assign accept    = bus.in_valid && bus.in_ready;
    assign last_step = (state == BUSY) && (step_cnt == CW'(WIDTH - 1));

    // State register; reset abandons any multiply in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: MUL detours through BUSY, everything else lands straight in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (bus.op == OP_MUL) ? BUSY : DONE;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: begin
                if (accept) begin
                    state_nxt = (bus.op == OP_MUL) ? BUSY : DONE;
                end else if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs; a consumed DONE can take the next op in the same cycle.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: bus.in_ready = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // Single-cycle ops evaluated straight from the request so the result registers on accept.
    always_comb begin
        sum      = {1'b0, bus.a} + {1'b0, bus.b};
        diff     = bus.a - bus.b;
        shamt    = bus.b % W_VEC;
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        case (bus.op)
            OP_ADD: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
            end
            OP_SUB: begin
                alu_res  = diff;
                alu_cout = (bus.a < bus.b);
                alu_ovf  = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SHL:  alu_res = bus.a << shamt;
            OP_SHR:  alu_res = bus.a >> shamt;
            default: ;
        endcase
    end

    // One shift-add step: conditionally add the multiplicand to the high half, then shift right.
    // The multiplier sits in the low half and is consumed one bit per step.
    always_comb begin
        part_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {part_sum, prod[WIDTH-1:1]};
    end

    // Multiply sequencer: load operands on a MUL accept, iterate once per BUSY cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
            mcand    <= '0;
            prod     <= '0;
        end else if (accept && (bus.op == OP_MUL)) begin
            step_cnt <= '0;
            mcand    <= bus.a;
            prod     <= {{WIDTH{1'b0}}, bus.b};
        end else if (state == BUSY) begin
            step_cnt <= step_cnt + CW'(1);
            prod     <= prod_nxt;
        end
    end

    // Result/flag registers only change on entry to DONE, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.res    <= '0;
            bus.res_hi <= '0;
            bus.cout   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
        end else if (accept && (bus.op != OP_MUL)) begin
            bus.res    <= alu_res;
            bus.res_hi <= '0;
            bus.cout   <= alu_cout;
            bus.ovf    <= alu_ovf;
            bus.zero   <= (alu_res == '0);
        end else if (last_step) begin
            bus.res    <= prod_nxt[WIDTH-1:0];
            bus.res_hi <= prod_nxt[2*WIDTH-1:WIDTH];
            bus.cout   <= |prod_nxt[2*WIDTH-1:WIDTH];
            bus.ovf    <= 1'b0;
            bus.zero   <= (prod_nxt[WIDTH-1:0] == '0);
        end
    end
endmodule

// File: tb/tb_alu_seq_core.sv
// Scoreboard bench for alu_seq_core: directed WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
// Latency: expected results queued at accept, popped by per-DUT monitors on each output handshake.
// Backpressure: out_ready is held low in places to check hold behaviour and the in_ready coupling.
module tb_alu_seq_core;
    typedef struct packed {
        logic [7:0] hi;
        logic [7:0] lo;
        logic       c;
        logic       v;
        logic       z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(8)) b8();
    alu_seq_if #(.WIDTH(4)) b4();

    alu_seq_core #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));
    alu_seq_core #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] hi, input logic [7:0] lo, input logic c,
                                input logic v, input logic z);
        exp_t e;
        e.hi = hi; e.lo = lo; e.c = c; e.v = v; e.z = z;
        return e;
    endfunction

    // Independent 4-bit reference for the exhaustive sweep.
    function automatic exp_t model4(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        logic [7:0] p;
        logic [3:0] r;
        logic [3:0] h;
        logic       c;
        logic       v;
        h = 4'h0; c = 1'b0; v = 1'b0; r = 4'h0; s = 5'h0; p = 8'h0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[3:0]; c = s[4];
                v = (x[3] == y[3]) && (r[3] != x[3]);
            end
            3'd1: begin
                r = x - y; c = (x < y);
                v = (x[3] != y[3]) && (r[3] != x[3]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = x << y[1:0];
            3'd6: r = x >> y[1:0];
            default: begin
                p = {4'h0, x} * {4'h0, y};
                r = p[3:0]; h = p[7:4]; c = (h != 4'h0);
            end
        endcase
        return mk({4'h0, h}, {4'h0, r}, c, v, (r == 4'h0));
    endfunction

    // Monitors: pop one expectation per completed output handshake.
    always @(negedge clk) begin
        if (!rst && b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) begin
                chk("w8_unexpected_out", {13'h0, b8.res_hi, b8.res, b8.cout, b8.ovf, b8.zero}, 32'hFFFFFFFF);
            end else begin
                chk("w8_result", {13'h0, b8.res_hi, b8.res, b8.cout, b8.ovf, b8.zero}, {13'h0, q8.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                chk("w4_unexpected_out", {21'h0, b4.res_hi, b4.res, b4.cout, b4.ovf, b4.zero}, 32'hFFFFFFFF);
            end else begin
                chk("w4_result", {13'h0, 4'h0, b4.res_hi, 4'h0, b4.res, b4.cout, b4.ovf, b4.zero},
                    {13'h0, q4.pop_front()});
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input bit w4, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                         input exp_t e);
        int  n;
        logic rdy;
        n = 0;
        if (w4) begin
            b4.in_valid = 1'b1; b4.op = o; b4.a = x[3:0]; b4.b = y[3:0];
        end else begin
            b8.in_valid = 1'b1; b8.op = o; b8.a = x; b8.b = y;
        end
        @(negedge clk);
        rdy = w4 ? b4.in_ready : b8.in_ready;
        while (!rdy && n < 64) begin
            @(negedge clk);
            n++;
            rdy = w4 ? b4.in_ready : b8.in_ready;
        end
        if (!rdy) begin
            chk("issue_timeout", 32'd0, 32'd1);
        end else if (w4) begin
            q4.push_back(e);
        end else begin
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        b4.in_valid = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    logic [2:0] v_op[10] = '{3'd3, 3'd5, 3'd6, 3'd0, 3'd7, 3'd7, 3'd2, 3'd6, 3'd4, 3'd1};
    logic [7:0] v_a[10]  = '{8'h0F, 8'h81, 8'h81, 8'h7F, 8'h10, 8'h0F, 8'hAA, 8'h80, 8'hFF, 8'h05};
    logic [7:0] v_b[10]  = '{8'hF0, 8'h09, 8'h03, 8'h01, 8'h10, 8'h03, 8'h55, 8'h08, 8'hFF, 8'h05};
    exp_t       v_e[10];

    initial begin
        v_e[0] = mk(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        v_e[1] = mk(8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
        v_e[2] = mk(8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
        v_e[3] = mk(8'h00, 8'h80, 1'b0, 1'b1, 1'b0);
        v_e[4] = mk(8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        v_e[5] = mk(8'h00, 8'h2D, 1'b0, 1'b0, 1'b0);
        v_e[6] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        v_e[7] = mk(8'h00, 8'h80, 1'b0, 1'b0, 1'b0);
        v_e[8] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        v_e[9] = mk(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        b8.in_valid = 1'b0; b8.op = 3'd0; b8.a = 8'h0; b8.b = 8'h0; b8.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.op = 3'd0; b4.a = 4'h0; b4.b = 4'h0; b4.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_state", {b8.out_valid, b8.in_ready, b8.res, b8.res_hi, b8.cout, b8.ovf, b8.zero},
            {1'b0, 1'b1, 8'h00, 8'h00, 3'b000});
        align();

        // Reset mid-stream with a result still pending.
        b8.out_ready = 1'b0;
        issue(1'b0, 3'd0, 8'h01, 8'h01, mk(8'h00, 8'h02, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("pending_before_rst", {31'h0, b8.out_valid}, 32'd1);
        align();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        q8.delete();
        b8.out_ready = 1'b1;
        @(negedge clk);
        chk("midstream_reset", {b8.out_valid, b8.in_ready, b8.res, b8.res_hi, b8.cout, b8.ovf, b8.zero},
            {1'b0, 1'b1, 8'h00, 8'h00, 3'b000});
        align();

        // ADD wrap: one-cycle latency.
        issue(1'b0, 3'd0, 8'hFF, 8'h01, mk(8'h00, 8'h00, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        chk("add_latency_1", {31'h0, b8.out_valid}, 32'd1);
        align();

        // SUB signed overflow, then borrow.
        issue(1'b0, 3'd1, 8'h80, 8'h01, mk(8'h00, 8'h7F, 1'b0, 1'b1, 1'b0));
        issue(1'b0, 3'd1, 8'h01, 8'h02, mk(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0));

        // MUL 255*255: 8 busy cycles, result on the 9th.
        issue(1'b0, 3'd7, 8'hFF, 8'hFF, mk(8'hFE, 8'h01, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("mul_busy", {30'h0, b8.in_ready, b8.out_valid}, 32'd0);
        end
        @(negedge clk);
        chk("mul_latency_9", {31'h0, b8.out_valid}, 32'd1);
        align();

        // Output backpressure: held result, in_ready low, then accept on release.
        b8.out_ready = 1'b0;
        issue(1'b0, 3'd2, 8'hF0, 8'h3C, mk(8'h00, 8'h30, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("held_output", {b8.out_valid, b8.in_ready, b8.res, b8.res_hi, b8.cout, b8.ovf, b8.zero},
                {1'b1, 1'b0, 8'h30, 8'h00, 3'b000});
        end
        align();
        b8.out_ready = 1'b1;
        issue(1'b0, 3'd4, 8'hF0, 8'h3C, mk(8'h00, 8'hCC, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("xor_after_release", {24'h0, b8.res}, 32'h0000_00CC);
        align();

        // Back-to-back directed vectors.
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, v_op[i], v_a[i], v_b[i], v_e[i]);
        end

        // Reset on the 4th busy cycle of a MUL.
        align();
        issue(1'b0, 3'd7, 8'h03, 8'h04, mk(8'h00, 8'h0C, 1'b0, 1'b0, 1'b0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        q8.delete();
        @(negedge clk);
        chk("mul_abort_idle", {b8.out_valid, b8.in_ready, b8.res_hi}, {1'b0, 1'b1, 8'h00});
        align();
        issue(1'b0, 3'd0, 8'h03, 8'h04, mk(8'h00, 8'h07, 1'b0, 1'b0, 1'b0));

        // WIDTH=4 exhaustive sweep against the reference model.
        for (int o = 0; o < 8; o++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    issue(1'b1, 3'(o), 8'(x), 8'(y), model4(3'(o), 4'(x), 4'(y)));
                end
            end
        end

        for (int n = 0; n < 200 && (q8.size() != 0 || q4.size() != 0); n++) begin
            @(negedge clk);
        end
        chk("drain_q8", q8.size(), 32'd0);
        chk("drain_q4", q4.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
